// File: rtl/adc_clock_divider.sv
// adc_clock_divider: NUM_CLOCKS registered divided clocks with edge strobes and runtime ratio updates.
// Build macro ADC_CLOCK_PHASE_EN adds cfg_phase, a start offset loaded when a new ratio is applied.
module adc_clock_divider #(
    parameter int NUM_CLOCKS  = 2,
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_channel,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
`ifdef ADC_CLOCK_PHASE_EN
    input  logic [DIV_WIDTH-1:0]  cfg_phase,
`endif
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_stb,
    output logic                  locked
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO     = DIV_WIDTH'(2);
    localparam int                   LCW     = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCW-1:0]       LOCK_MAX  = LCW'(LOCK_CYCLES);
    localparam logic [LCW-1:0]       LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    logic [DIV_WIDTH-1:0] cnt      [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0] div      [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0] cnt_next [NUM_CLOCKS];
    logic [DIV_WIDTH-1:0] div_next [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] apply;

    logic                 pend_valid;
    logic [CH_W-1:0]      pend_ch;
    logic [DIV_WIDTH-1:0] pend_div;
    logic [DIV_WIDTH-1:0] start_cnt;
    logic [LCW-1:0]       lock_cnt;

    logic                 accept;
    logic                 ch_ok;
    logic [DIV_WIDTH-1:0] div_clamped;

    // Handshake: a request is taken on any rising edge with cfg_valid && cfg_ready.
    // cfg_ready is held low only while a valid-channel request waits for its channel's wrap.
    assign accept      = cfg_valid && cfg_ready;
    assign ch_ok       = (int'(cfg_channel) < NUM_CLOCKS);
    assign div_clamped = (cfg_div < TWO) ? TWO : cfg_div;

`ifdef ADC_CLOCK_PHASE_EN
    logic [DIV_WIDTH-1:0] pend_phase;
    assign start_cnt = (pend_phase >= pend_div) ? '0 : pend_phase;
`else
    assign start_cnt = '0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            apply[i]    = 1'b0;
            div_next[i] = div[i];
            cnt_next[i] = cnt[i] + ONE;
            if (cnt[i] == div[i] - ONE) begin
                cnt_next[i] = '0;
                // Only a wrap edge may swap the ratio, so no period is ever cut short.
                if (pend_valid && (pend_ch == CH_W'(i))) begin
                    apply[i]    = 1'b1;
                    div_next[i] = pend_div;
                    cnt_next[i] = start_cnt;
                end
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                cnt[i] <= DEF_DIV - ONE;
                div[i] <= DEF_DIV;
            end
            outclk     <= '0;
            outclk_stb <= '0;
            cfg_ready  <= 1'b0;
            locked     <= 1'b0;
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            pend_div   <= DEF_DIV;
            lock_cnt   <= '0;
`ifdef ADC_CLOCK_PHASE_EN
            pend_phase <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                cnt[i]        <= cnt_next[i];
                div[i]        <= div_next[i];
                outclk[i]     <= (cnt_next[i] < (div_next[i] >> 1));
                outclk_stb[i] <= (cnt_next[i] == '0);
            end

            if (accept && ch_ok) begin
                pend_valid <= 1'b1;
                pend_ch    <= cfg_channel;
                pend_div   <= div_clamped;
`ifdef ADC_CLOCK_PHASE_EN
                pend_phase <= cfg_phase;
`endif
                cfg_ready  <= 1'b0;
                locked     <= 1'b0;
                lock_cnt   <= '0;
            end else if (pend_valid) begin
                if (|apply) begin
                    pend_valid <= 1'b0;
                    cfg_ready  <= 1'b1;
                end
            end else begin
                // Out-of-range channel requests land here too: dropped without disturbing lock.
                cfg_ready <= 1'b1;
                if (lock_cnt != LOCK_MAX) begin
                    lock_cnt <= lock_cnt + LCW'(1);
                    if (lock_cnt == LOCK_LAST) locked <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_clock_divider.sv
// tb_adc_clock_divider: directed and randomized checks of adc_clock_divider against a period-arithmetic model.
// Three channels are used so that an out-of-range channel number fits in cfg_channel.
module tb_adc_clock_divider;

    localparam int NC  = 3;
    localparam int DW  = 8;
    localparam int DEF = 4;
    localparam int LC  = 16;
    localparam int CHW = 2;
    localparam int VW  = 2 * NC + 2;

    logic          refclk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CHW-1:0] cfg_channel = '0;
    logic [DW-1:0] cfg_div = '0;
    logic [DW-1:0] cfg_phase = '0;
    logic [NC-1:0] outclk;
    logic [NC-1:0] outclk_stb;
    logic          locked;

    adc_clock_divider #(
        .NUM_CLOCKS (NC),
        .DIV_WIDTH  (DW),
        .DEFAULT_DIV(DEF),
        .LOCK_CYCLES(LC)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_channel(cfg_channel),
        .cfg_div    (cfg_div),
`ifdef ADC_CLOCK_PHASE_EN
        .cfg_phase  (cfg_phase),
`endif
        .outclk     (outclk),
        .outclk_stb (outclk_stb),
        .locked     (locked)
    );

    always #5 refclk = ~refclk;

    // Model: each channel's position at edge e is (e - base) mod n.
    int   edge_no = 0;
    int   m_n[NC];
    int   m_base[NC];
    bit   m_pend = 0;
    int   m_pch, m_pn, m_pph;
    bit   m_ready = 0;
    bit   m_locked = 0;
    int   m_lock = 0;
    logic [NC-1:0] exp_clk = '0;
    logic [NC-1:0] exp_stb = '0;
    int   checks = 0;
    int   passes = 0;

    function automatic int pos_at(int c, int e);
        int x;
        x = (e - m_base[c]) % m_n[c];
        if (x < 0) x += m_n[c];
        return x;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {exp_clk, exp_stb, m_ready, m_locked};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {outclk, outclk_stb, cfg_ready, locked};
    endfunction

    // Advance one clock and update the model from the inputs present at that edge.
    task automatic step();
        bit applied;
        int p;
        @(posedge refclk);
        edge_no++;
        applied = 0;
        if (!rst) begin
            for (int c = 0; c < NC; c++) begin
                m_n[c]    = DEF;
                m_base[c] = edge_no + 1;
            end
            m_pend = 0; m_ready = 0; m_locked = 0; m_lock = 0;
            exp_clk = '0; exp_stb = '0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (m_pend && m_pch == c && pos_at(c, edge_no) == 0) begin
                    m_n[c]    = m_pn;
                    m_base[c] = edge_no - ((m_pph >= m_pn) ? 0 : m_pph);
                    applied   = 1;
                end
                p = pos_at(c, edge_no);
                exp_clk[c] = (p < m_n[c] / 2);
                exp_stb[c] = (p == 0);
            end
            if (cfg_valid && m_ready && cfg_channel < NC) begin
                m_pend = 1;
                m_pch  = int'(cfg_channel);
                m_pn   = (cfg_div < 2) ? 2 : int'(cfg_div);
`ifdef ADC_CLOCK_PHASE_EN
                m_pph  = int'(cfg_phase);
`else
                m_pph  = 0;
`endif
                m_ready = 0; m_locked = 0; m_lock = 0;
            end else if (m_pend) begin
                if (applied) begin
                    m_pend = 0;
                    m_ready = 1;
                end
            end else begin
                m_ready = 1;
                if (m_lock < LC) begin
                    m_lock++;
                    if (m_lock == LC) m_locked = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] want;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (dut_vec() !== '0) $display("FAIL reset_hold edge %0d: got %b want %b", edge_no, dut_vec(), {VW{1'b0}});
            else passes++;
        end
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            want = {(((k - 1) % 4) < 2) ? {NC{1'b1}} : {NC{1'b0}},
                    (((k - 1) % 4) == 0) ? {NC{1'b1}} : {NC{1'b0}},
                    1'b1, (k >= LC)};
            checks++;
            if (dut_vec() !== want) $display("FAIL reset_release edge %0d: got %b want %b", k, dut_vec(), want);
            else passes++;
        end
    endtask

    task automatic test_reconfig();
        for (int i = 0; i < 8 && pos_at(1, edge_no) != 1; i++) step();
        cfg_valid = 1'b1; cfg_channel = 2'd1; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (locked !== 1'b0 || cfg_ready !== 1'b0)
            $display("FAIL reconfig_accept: got locked=%b ready=%b want 0 0", locked, cfg_ready);
        else passes++;
        for (int k = 0; k < 40; k++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL reconfig edge %0d: got %b want %b", edge_no, dut_vec(), exp_vec());
            else passes++;
        end
    endtask

    task automatic test_wrap_accept();
        for (int i = 0; i < 8 && pos_at(0, edge_no) != m_n[0] - 1; i++) step();
        cfg_valid = 1'b1; cfg_channel = 2'd0; cfg_div = 8'd6;
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL wrap_accept edge %0d: got %b want %b", edge_no, dut_vec(), exp_vec());
            else passes++;
        end
    endtask

    task automatic test_clamp();
        logic [DW-1:0] divs [2];
        divs[0] = 8'd0; divs[1] = 8'd1;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 12 && !m_ready; i++) step();
            cfg_valid = 1'b1; cfg_channel = CHW'(2 * t); cfg_div = divs[t];
            step();
            cfg_valid = 1'b0;
            for (int k = 0; k < 14; k++) begin
                step();
                checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL clamp%0d edge %0d: got %b want %b", t, edge_no, dut_vec(), exp_vec());
                else passes++;
            end
        end
    endtask

    task automatic test_bad_channel();
        for (int i = 0; i < 40 && !m_locked; i++) step();
        cfg_valid = 1'b1; cfg_channel = 2'd3; cfg_div = 8'd7;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1 || locked !== 1'b1)
            $display("FAIL bad_channel: got ready=%b locked=%b want 1 1", cfg_ready, locked);
        else passes++;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL bad_channel edge %0d: got %b want %b", edge_no, dut_vec(), exp_vec());
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        cfg_valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            cfg_channel = CHW'($urandom_range(0, 2));
            cfg_div     = DW'($urandom_range(0, 7));
            cfg_phase   = DW'($urandom_range(0, 7));
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL back_to_back edge %0d: got %b want %b", edge_no, dut_vec(), exp_vec());
            else passes++;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst         = ($urandom_range(0, 99) != 0);
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_channel = CHW'($urandom_range(0, 3));
            cfg_div     = DW'($urandom_range(0, 9));
            cfg_phase   = DW'($urandom_range(0, 9));
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL random edge %0d: got %b want %b", edge_no, dut_vec(), exp_vec());
            else passes++;
        end
        rst = 1'b1; cfg_valid = 1'b0; cfg_phase = '0;
    endtask

`ifdef ADC_CLOCK_PHASE_EN
    task automatic test_phase();
        rst = 1'b0; step(); rst = 1'b1;
        step();
        cfg_valid = 1'b1; cfg_channel = 2'd1; cfg_div = 8'd4; cfg_phase = 8'd2;
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL phase edge %0d: got %b want %b", edge_no, dut_vec(), exp_vec());
            else passes++;
        end
        checks++;
        if (outclk[1] !== ~outclk[0]) $display("FAIL phase_antiphase: got ch1=%b want %b", outclk[1], ~outclk[0]);
        else passes++;
        cfg_valid = 1'b1; cfg_channel = 2'd1; cfg_div = 8'd6; cfg_phase = 8'd3;
        step();
        cfg_valid = 1'b0; rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 24; k++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL phase_reset edge %0d: got %b want %b", edge_no, dut_vec(), exp_vec());
            else passes++;
        end
    endtask
`endif

    initial begin
        for (int c = 0; c < NC; c++) begin
            m_n[c] = DEF;
            m_base[c] = 0;
        end
        test_reset();
        test_reconfig();
        test_wrap_accept();
        test_clamp();
        test_bad_channel();
        test_back_to_back();
        test_random();
`ifdef ADC_CLOCK_PHASE_EN
        test_phase();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
